// File: rtl/dut_alu_pipe_if.sv
// Handshake/operand/result bundle for dut_alu_pipe; DATA_W must match the unit's DATA_W.
interface dut_alu_pipe_if #(
    parameter int unsigned DATA_W = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_W-1:0]     i_data_A;
    logic [DATA_W-1:0]     i_data_B;
    logic [1:0]            i_op;
    logic                  i_acc_clr;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*DATA_W-1:0]   o_data;
    logic                  o_ovf;

    modport slave (
        input  i_valid, i_data_A, i_data_B, i_op, i_acc_clr, i_ready,
        output o_ready, o_valid, o_data, o_ovf
    );

    modport master (
        output i_valid, i_data_A, i_data_B, i_op, i_acc_clr, i_ready,
        input  o_ready, o_valid, o_data, o_ovf
    );
endinterface

// File: rtl/dut_alu_pipe.sv
// Pipelined mul/add/sub/mac unit with valid/ready handshake and a STAGES-deep stall pipeline.
// Define DUT_ALU_MAC_EN to build the accumulator; otherwise op 11 behaves as mul.
module dut_alu_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    dut_alu_pipe_if.slave  bus
);
    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned SUM_W = RES_W + 1;

    logic                          adv_c;
    logic                          accept_c;
    logic [RES_W-1:0]              prod_c;
    logic [RES_W-1:0]              res_c;
    logic                          res_ovf_c;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0]             ovf_q, ovf_d;
    logic [STAGES-1:0][RES_W-1:0]  data_q, data_d;

    // Stage g takes its input from stage g-1; index 0 of the extended vectors is the new result
    logic [STAGES:0]               valid_ext_c;
    logic [STAGES:0]               ovf_ext_c;
    logic [STAGES:0][RES_W-1:0]    data_ext_c;

    assign adv_c    = !valid_q[STAGES-1] || bus.i_ready;
    assign accept_c = bus.i_valid && adv_c;
    assign prod_c   = RES_W'(bus.i_data_A) * RES_W'(bus.i_data_B);

`ifdef DUT_ALU_MAC_EN
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] acc_base_c;

    assign acc_base_c = bus.i_acc_clr ? '0 : acc_q;
`else
    logic unused_acc_clr;

    assign unused_acc_clr = bus.i_acc_clr;
`endif

    // Result of the operation presented at the input, plus accumulator update on an accepted mac
    always_comb begin
        res_c     = prod_c;
        res_ovf_c = 1'b0;
`ifdef DUT_ALU_MAC_EN
        acc_d     = acc_q;
`endif
        case (bus.i_op)
            2'b01: res_c = RES_W'(bus.i_data_A) + RES_W'(bus.i_data_B);
            2'b10: begin
                res_c     = RES_W'(bus.i_data_A) - RES_W'(bus.i_data_B);
                res_ovf_c = bus.i_data_A < bus.i_data_B;
            end
`ifdef DUT_ALU_MAC_EN
            2'b11: begin
                {res_ovf_c, res_c} = SUM_W'(acc_base_c) + SUM_W'(prod_c);
                if (accept_c) begin
                    acc_d = res_c;
                end
            end
`endif
            default: res_c = prod_c;
        endcase
    end

    assign valid_ext_c = {valid_q, accept_c};
    assign ovf_ext_c   = {ovf_q, res_ovf_c};
    assign data_ext_c  = {data_q, res_c};

    // Valid bits shift on every advance; payloads load only behind a valid entry
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign valid_d[g] = adv_c ? valid_ext_c[g] : valid_q[g];
        assign ovf_d[g]   = (adv_c && valid_ext_c[g]) ? ovf_ext_c[g]  : ovf_q[g];
        assign data_d[g]  = (adv_c && valid_ext_c[g]) ? data_ext_c[g] : data_q[g];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            ovf_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
        end
    end

`ifdef DUT_ALU_MAC_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign bus.o_ready = adv_c;
    assign bus.o_valid = valid_q[STAGES-1];
    assign bus.o_data  = data_q[STAGES-1];
    assign bus.o_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_dut_alu_pipe.sv
// Randomized and directed bench for dut_alu_pipe against a queue-based arithmetic model.
module tb_dut_alu_pipe;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned STAGES = 2;

    typedef struct {
        logic [16:0] res;
        int          step;
        int          stall;
    } exp_t;

    logic clk;
    logic rst;

    dut_alu_pipe_if #(.DATA_W(DATA_W)) bus ();

    dut_alu_pipe #(.DATA_W(DATA_W), .STAGES(STAGES)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          step_no = 0;
    int          n_stall = 0;
    longint      acc_m = 0;
    exp_t        sb[$];
    logic [16:0] got_q[$];
    bit          accepted;
    bit          last_ready;
    bit          held = 0;
    logic [15:0] held_data;
    logic        held_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, step_no);
        end
    endtask

    // Reference arithmetic from the operation rules; returns {ovf, result}
    function automatic logic [16:0] model(input int a, input int b, input int op, input bit clr);
        longint r;
        bit     ovf;
        ovf = 1'b0;
        case (op)
            1: r = a + b;
            2: begin
                r   = longint'(a - b) & 64'hFFFF;
                ovf = (a < b);
            end
            3: begin
`ifdef DUT_ALU_MAC_EN
                r     = (clr ? 0 : acc_m) + a * b;
                ovf   = (r > 64'hFFFF);
                r     = r & 64'hFFFF;
                acc_m = r;
`else
                r = a * b;
`endif
            end
            default: r = a * b;
        endcase
        return {ovf, r[15:0]};
    endfunction

    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input bit clr, input bit rdy, input bit rs);
        bit          ov;
        bit          orr;
        logic [15:0] od;
        logic        oo;
        exp_t        e;
        bus.i_valid   = v;
        bus.i_data_A  = a;
        bus.i_data_B  = b;
        bus.i_op      = op;
        bus.i_acc_clr = clr;
        bus.i_ready   = rdy;
        rst           = rs;
        accepted      = 1'b0;
        @(negedge clk);
        ov  = bus.o_valid;
        orr = bus.o_ready;
        od  = bus.o_data;
        oo  = bus.o_ovf;
        last_ready = orr;
        if (rs) begin
            sb.delete();
            acc_m = 0;
            held  = 1'b0;
        end else begin
            chk("ready_rule", 32'(orr), 32'(!ov || rdy));
            if (held) begin
                chk("stall_data", 32'(od), 32'(held_data));
                chk("stall_ovf", 32'(oo), 32'(held_ovf));
                chk("stall_valid", 32'(ov), 32'd1);
            end
            held = 1'b0;
            if (ov) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(ov), 32'd0);
                end else if (rdy) begin
                    e = sb.pop_front();
                    chk("result", 32'({oo, od}), 32'(e.res));
                    chk("latency", 32'(step_no - e.step - (n_stall - e.stall)), 32'(STAGES));
                    got_q.push_back({oo, od});
                end else begin
                    n_stall++;
                    held      = 1'b1;
                    held_data = od;
                    held_ovf  = oo;
                end
            end
            if (v && orr) begin
                e.res   = model(int'(a), int'(b), int'(op), clr);
                e.step  = step_no;
                e.stall = n_stall;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input bit clr);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, a, b, op, clr, 1'b1, 1'b0);
            if (accepted) return;
        end
        chk("send_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [16:0] exp);
        logic [16:0] g;
        g = (idx < got_q.size()) ? got_q[idx] : 17'h0DEAD;
        chk(tag, 32'(g), 32'(exp));
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_data_A  = '0;
        bus.i_data_B  = '0;
        bus.i_op      = '0;
        bus.i_acc_clr = 1'b0;
        bus.i_ready   = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with valid asserted
        repeat (3) step(1'b1, 8'h02, 8'h03, 2'b11, 1'b0, 1'b1, 1'b1);
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_data", 32'(bus.o_data), 32'h0);
        chk("rst_o_ovf", 32'(bus.o_ovf), 32'd0);
        chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
        got_q.delete();
        send(8'h02, 8'h03, 2'b11, 1'b0);
        drain(4);
        chk("post_rst_mac", 32'(got_q.size()), 32'd1);
        chk_got("post_rst_mac_val", 0, 17'h00006);

        // Back-to-back mixed ops
        got_q.delete();
        send(8'hFF, 8'hFF, 2'b00, 1'b0);
        send(8'hFF, 8'h01, 2'b01, 1'b0);
        send(8'h01, 8'h02, 2'b10, 1'b0);
        drain(4);
        chk_got("b2b_mul", 0, 17'h0FE01);
        chk_got("b2b_add", 1, 17'h00100);
        chk_got("b2b_sub", 2, 17'h1FFFF);

        // Backpressure mid-stream
        got_q.delete();
        send(8'h01, 8'h01, 2'b01, 1'b0);
        send(8'h02, 8'h02, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h03, 8'h03, 2'b01, 1'b0, 1'b0, 1'b0);
            chk("bp_o_ready", 32'(last_ready), 32'd0);
        end
        send(8'h03, 8'h03, 2'b01, 1'b0);
        send(8'h04, 8'h04, 2'b01, 1'b0);
        drain(4);
        chk("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_got("bp_val", i, 17'(2 * (i + 1)));

        // Accumulate sequence and wrap
        got_q.delete();
        send(8'h10, 8'h10, 2'b11, 1'b1);
        repeat (3) send(8'h10, 8'h10, 2'b11, 1'b0);
        send(8'h01, 8'h01, 2'b11, 1'b1);
        send(8'hFF, 8'hFF, 2'b11, 1'b1);
        send(8'hFF, 8'hFF, 2'b11, 1'b0);
        drain(4);
`ifdef DUT_ALU_MAC_EN
        chk_got("mac_0", 0, 17'h00100);
        chk_got("mac_1", 1, 17'h00200);
        chk_got("mac_2", 2, 17'h00300);
        chk_got("mac_3", 3, 17'h00400);
        chk_got("mac_clr", 4, 17'h00001);
        chk_got("mac_wrap", 6, 17'h1FC02);
`else
        chk_got("op3_0", 0, 17'h00100);
        chk_got("op3_3", 3, 17'h00100);
        chk_got("op3_clr", 4, 17'h00001);
        chk_got("op3_ff", 6, 17'h0FE01);
`endif

        // Reset with two transactions in flight
        send(8'h05, 8'h05, 2'b11, 1'b0);
        send(8'h06, 8'h06, 2'b00, 1'b0);
        got_q.delete();
        step(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
        send(8'h01, 8'h01, 2'b11, 1'b0);
        drain(4);
        chk("midrst_count", 32'(got_q.size()), 32'd1);
        chk_got("midrst_mac", 0, 17'h00001);

        // Op 11 of 3x4, twice
        got_q.delete();
        send(8'h03, 8'h04, 2'b11, 1'b1);
        send(8'h03, 8'h04, 2'b11, 1'b0);
        drain(4);
        chk_got("op3_first", 0, 17'h0000C);
`ifdef DUT_ALU_MAC_EN
        chk_got("op3_second", 1, 17'h00018);
`else
        chk_got("op3_second", 1, 17'h0000C);
`endif

        // Random traffic with random backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        drain(STAGES + 4);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
